// File: rtl/prog_fetch_memory_pkg.sv
// ============================================================================
// Module : prog_fetch_memory_pkg
// Brief  : Shared state encodings and default sizing for the fetch memory.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_fetch_memory_pkg;

    localparam int c_DEF_WIDTH      = 5;
    localparam int c_DEF_ADDR_WIDTH = 32;
    localparam int c_DEF_DEPTH      = 256;
    localparam int c_STATE_W        = 2;

    typedef enum logic [c_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Index width for a DEPTH-entry array, never narrower than one bit.
    function automatic int f_idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_mem_array.sv
// ============================================================================
// Module : prog_mem_array
// Brief  : Identity-initialised storage, one write port, registered read.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_mem_array
    import prog_fetch_memory_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DEPTH      = c_DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [WIDTH-1:0]      o_rd_data
);

    localparam int                  c_IDX_W   = f_idx_width(DEPTH);
    localparam logic [ADDR_WIDTH:0] c_DEPTH_X = (ADDR_WIDTH+1)'(DEPTH);

    logic [WIDTH-1:0] w_mem [DEPTH];
    logic             w_rd_in_range;
    logic [WIDTH-1:0] r_rd_data;

    // Each word carries its own power-up value; rst only touches the read register.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [WIDTH-1:0] r_word = WIDTH'(gi);

            always_ff @(posedge clk) begin
                if (i_wr_en && (i_wr_addr == ADDR_WIDTH'(gi))) begin
                    r_word <= i_wr_data;
                end
            end

            assign w_mem[gi] = r_word;
        end
    endgenerate

    assign w_rd_in_range = ({1'b0, i_rd_addr} < c_DEPTH_X);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
        end else if (i_rd_en) begin
            r_rd_data <= w_rd_in_range ? w_mem[i_rd_addr[c_IDX_W-1:0]] : '0;
        end
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/prog_fetch_memory.sv
// ============================================================================
// Module : prog_fetch_memory
// Brief  : Self-fetching program store streaming words on valid/ready.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_fetch_memory
    import prog_fetch_memory_pkg::*;
#(
    parameter int WIDTH      = c_DEF_WIDTH,
    parameter int ADDR_WIDTH = c_DEF_ADDR_WIDTH,
    parameter int DEPTH      = c_DEF_DEPTH,
    parameter int WRAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic                  jump_valid,
    input  logic [ADDR_WIDTH-1:0] jump_addr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic                  busy,
    output logic                  done
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST = ADDR_WIDTH'(DEPTH - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] w_pc_nxt;
    logic                  r_valid;
    logic                  w_valid_nxt;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic                  w_advance;
    logic                  w_fetch;
    logic                  w_wr_en;

    assign w_advance = (r_state == ST_RUN) && (!r_valid || out_ready);
    assign w_wr_en   = wr_en && !reset;

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_valid_nxt = r_valid;
        w_fetch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_pc_nxt    = start_addr;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                // A redirect flushes the presented word and skips this cycle's fetch.
                if (start || jump_valid) begin
                    w_pc_nxt    = start ? start_addr : jump_addr;
                    w_valid_nxt = 1'b0;
                end else if (w_advance) begin
                    w_fetch     = 1'b1;
                    w_valid_nxt = 1'b1;
                    if (r_pc >= c_LAST) begin
                        if (WRAP != 0) begin
                            w_pc_nxt = '0;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end else begin
                        w_pc_nxt = r_pc + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                if (start) begin
                    w_pc_nxt    = start_addr;
                    w_valid_nxt = 1'b0;
                    w_state_nxt = ST_RUN;
                end else if (r_valid && out_ready) begin
                    w_valid_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_pc       <= '0;
            r_valid    <= 1'b0;
            r_out_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_valid <= w_valid_nxt;
            if (w_fetch) begin
                r_out_addr <= r_pc;
            end
        end
    end

    prog_mem_array #(
        .WIDTH      (WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk       (clk),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (wr_addr),
        .i_wr_data (wr_data),
        .i_rd_en   (w_fetch),
        .i_rd_addr (r_pc),
        .o_rd_data (out_data)
    );

    assign out_valid = r_valid;
    assign out_addr  = r_out_addr;
    assign busy      = (r_state == ST_RUN);
    assign done      = (r_state == ST_DONE);

endmodule

`default_nettype wire

// File: tb/tb_prog_fetch_memory.sv
// ============================================================================
// Module : tb_prog_fetch_memory
// Brief  : Directed and random checks of two instances (no-wrap and wrap).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_fetch_memory;

    localparam int c_W     = 5;
    localparam int c_AW    = 8;
    localparam int c_DEPTH = 16;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            wr_en = 1'b0;
    logic [c_AW-1:0] wr_addr = '0;
    logic [c_W-1:0]  wr_data = '0;
    logic            start = 1'b0;
    logic [c_AW-1:0] start_addr = '0;
    logic            jump_valid = 1'b0;
    logic [c_AW-1:0] jump_addr = '0;
    logic            out_ready = 1'b0;

    logic [1:0]      dv;
    logic [1:0]      db;
    logic [1:0]      dn;
    logic [c_W-1:0]  dd0;
    logic [c_W-1:0]  dd1;
    logic [c_AW-1:0] da0;
    logic [c_AW-1:0] da1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    prog_fetch_memory #(.WIDTH(c_W), .ADDR_WIDTH(c_AW), .DEPTH(c_DEPTH), .WRAP(0)) dut0 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .out_valid(dv[0]), .out_ready(out_ready), .out_data(dd0), .out_addr(da0),
        .busy(db[0]), .done(dn[0])
    );

    prog_fetch_memory #(.WIDTH(c_W), .ADDR_WIDTH(c_AW), .DEPTH(c_DEPTH), .WRAP(1)) dut1 (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .start_addr(start_addr), .jump_valid(jump_valid), .jump_addr(jump_addr),
        .out_valid(dv[1]), .out_ready(out_ready), .out_data(dd1), .out_addr(da1),
        .busy(db[1]), .done(dn[1])
    );

    function automatic int g_data(input int w);
        return (w == 0) ? int'(dd0) : int'(dd1);
    endfunction

    function automatic int g_addr(input int w);
        return (w == 0) ? int'(da0) : int'(da1);
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed expectation: valid flag, and the word/address when valid.
    task automatic chk_word(input string tag, input int w, input int v, input int d, input int a);
        chk($sformatf("%s dut%0d valid", tag, w), int'(dv[w]), v);
        if (v != 0) begin
            chk($sformatf("%s dut%0d data", tag, w), g_data(w), d);
            chk($sformatf("%s dut%0d addr", tag, w), g_addr(w), a);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: program counter walk over a plain int array.
    // mode 0 = idle, 1 = running, 2 = finished.
    int m_mem [c_DEPTH];
    int m_mode  [2];
    int m_pc    [2];
    int m_valid [2];
    int m_data  [2];
    int m_addr  [2];
    bit m_ok = 1'b0;

    initial begin
        for (int i = 0; i < c_DEPTH; i++) m_mem[i] = i;
        for (int w = 0; w < 2; w++) begin
            m_mode[w] = 0; m_pc[w] = 0; m_valid[w] = 0; m_data[w] = 0; m_addr[w] = 0;
        end
        forever begin
            @(posedge clk);
            for (int w = 0; w < 2; w++) begin
                if (reset) begin
                    m_mode[w] = 0; m_pc[w] = 0; m_valid[w] = 0; m_data[w] = 0; m_addr[w] = 0;
                end else if (m_mode[w] == 0) begin
                    if (start) begin
                        m_pc[w]   = int'(start_addr);
                        m_mode[w] = 1;
                    end
                end else if (m_mode[w] == 1) begin
                    if (start || jump_valid) begin
                        m_pc[w]    = start ? int'(start_addr) : int'(jump_addr);
                        m_valid[w] = 0;
                    end else if (m_valid[w] == 0 || out_ready) begin
                        m_data[w]  = (m_pc[w] < c_DEPTH) ? m_mem[m_pc[w]] : 0;
                        m_addr[w]  = m_pc[w];
                        m_valid[w] = 1;
                        if (m_pc[w] >= c_DEPTH - 1) begin
                            if (w == 1) m_pc[w] = 0;
                            else        m_mode[w] = 2;
                        end else begin
                            m_pc[w] = (m_pc[w] + 1) % 256;
                        end
                    end
                end else begin
                    if (start) begin
                        m_pc[w]    = int'(start_addr);
                        m_valid[w] = 0;
                        m_mode[w]  = 1;
                    end else if (m_valid[w] != 0 && out_ready) begin
                        m_valid[w] = 0;
                    end
                end
            end
            if (!reset && wr_en && wr_addr < c_DEPTH) m_mem[wr_addr] = int'(wr_data);
            if (reset) m_ok = 1'b1;
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            for (int w = 0; w < 2; w++) begin
                chk($sformatf("model dut%0d valid", w), int'(dv[w]), m_valid[w]);
                chk($sformatf("model dut%0d busy", w), int'(db[w]), int'(m_mode[w] == 1));
                chk($sformatf("model dut%0d done", w), int'(dn[w]), int'(m_mode[w] == 2));
                if (m_valid[w] != 0 || m_mode[w] == 0) begin
                    chk($sformatf("model dut%0d data", w), g_data(w), m_data[w]);
                    chk($sformatf("model dut%0d addr", w), g_addr(w), m_addr[w]);
                end
            end
        end
    end

    initial begin
        // Reset state
        tick(); tick();
        for (int w = 0; w < 2; w++) begin
            chk_word("reset", w, 0, 0, 0);
            chk($sformatf("reset dut%0d data", w), g_data(w), 0);
            chk($sformatf("reset dut%0d addr", w), g_addr(w), 0);
            chk($sformatf("reset dut%0d busy", w), int'(db[w]), 0);
            chk($sformatf("reset dut%0d done", w), int'(dn[w]), 0);
        end
        reset = 1'b0;

        // Stream from 0 with two-edge latency
        start = 1'b1; start_addr = 8'd0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        chk("start busy", int'(db[0]), 1);
        chk_word("start lat", 0, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            tick();
            chk_word("stream", 0, 1, k, k);
        end

        // Back-pressure holds word 3
        start = 1'b1; start_addr = 8'd3;
        tick();
        start = 1'b0;
        tick();
        chk_word("bp first", 0, 1, 3, 3);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_word("bp hold", 0, 1, 3, 3);
        end
        out_ready = 1'b1;
        tick(); chk_word("bp next", 0, 1, 4, 4);
        tick(); chk_word("bp next", 0, 1, 5, 5);

        // Load port and read-old collision
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 5'd31;
        tick();
        wr_en = 1'b0;
        start = 1'b1; start_addr = 8'd4;
        tick();
        start = 1'b0;
        tick(); chk_word("load", 0, 1, 4, 4);
        tick(); chk_word("load", 0, 1, 31, 5);
        tick(); chk_word("load", 0, 1, 6, 6);
        wr_en = 1'b1; wr_addr = 8'd7; wr_data = 5'd0;
        tick(); chk_word("collide", 0, 1, 7, 7);
        wr_en = 1'b0;

        // Jump while word 6 is accepted
        start = 1'b1; start_addr = 8'd6;
        tick();
        start = 1'b0;
        tick(); chk_word("pre jump", 0, 1, 6, 6);
        jump_valid = 1'b1; jump_addr = 8'd2;
        tick(); chk_word("jump bubble", 0, 0, 0, 0);
        jump_valid = 1'b0;
        for (int k = 2; k < 5; k++) begin
            tick(); chk_word("jump", 0, 1, k, k);
        end

        // End of program: dut0 stops, dut1 wraps
        start = 1'b1; start_addr = 8'd14;
        tick();
        start = 1'b0;
        tick(); chk_word("end", 0, 1, 14, 14); chk_word("wrap", 1, 1, 14, 14);
        tick(); chk_word("end", 0, 1, 15, 15); chk_word("wrap", 1, 1, 15, 15);
        chk("end done at last", int'(dn[0]), 1);
        tick();
        chk_word("end drained", 0, 0, 0, 0);
        chk("end done", int'(dn[0]), 1);
        chk("end busy", int'(db[0]), 0);
        chk_word("wrap", 1, 1, 0, 0);
        chk("wrap done", int'(dn[1]), 0);
        tick();
        chk_word("wrap", 1, 1, 1, 1);
        chk("end still done", int'(dn[0]), 1);
        start = 1'b1; start_addr = 8'd0;
        tick();
        start = 1'b0;
        chk("restart busy", int'(db[0]), 1);
        tick(); chk_word("restart", 0, 1, 0, 0);

        // Reset beats start, jump and write
        start = 1'b1; start_addr = 8'd8;
        tick();
        start = 1'b0;
        tick(); chk_word("pre reset", 0, 1, 8, 8);
        reset = 1'b1; start = 1'b1; start_addr = 8'd3; jump_valid = 1'b1; jump_addr = 8'd9;
        wr_en = 1'b1; wr_addr = 8'd5; wr_data = 5'd0;
        tick();
        chk_word("mid reset", 0, 0, 0, 0);
        chk("mid reset data", g_data(0), 0);
        chk("mid reset busy", int'(db[0]), 0);
        reset = 1'b0; start = 1'b0; jump_valid = 1'b0; wr_en = 1'b0;
        start = 1'b1; start_addr = 8'd5;
        tick();
        start = 1'b0;
        tick(); chk_word("mem kept", 0, 1, 31, 5);

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            reset      = ($urandom_range(0, 299) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = 8'($urandom_range(0, 19));
            wr_data    = 5'($urandom);
            start      = ($urandom_range(0, 24) == 0);
            start_addr = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            jump_valid = ($urandom_range(0, 14) == 0);
            jump_addr  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
            out_ready  = ($urandom_range(0, 9) < 7);
            tick();
        end
        reset = 1'b0; start = 1'b0; jump_valid = 1'b0; wr_en = 1'b0;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
